// File: rtl/pmem_responder.sv
// Line-granular physical-memory responder answering each read/write after LATENCY cycles.
// Optional protocol checker enabled by defining PMEM_ERRCHK_EN (pmem_error tied low otherwise).
module pmem_responder #(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         pmem_error
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, RECOVER} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              cnt;
  logic                    op_wr_p0;
  logic [INDEX_BITS-1:0]   idx_p0;
  logic [127:0]            wdata_p0;
  logic [127:0]            mem [2**INDEX_BITS];

  logic                    req;
  logic [INDEX_BITS-1:0]   addr_idx;
  logic [INDEX_BITS-1:0]   rd_idx;
  logic                    rd_op;
  logic                    unused_addr;

  assign req         = pmem_read | pmem_write;
  assign addr_idx    = pmem_address[INDEX_BITS+3:4];
  assign unused_addr = ^{pmem_address[3:0], pmem_address >> (INDEX_BITS + 4)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req)
        cnt <= 8'(LATENCY - 1);
      else if (state == BUSY)
        cnt <= cnt - 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == 8'd1) state_nxt = RESP;
      RESP:    state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pmem_resp = (state == RESP);
  end

  // p0: request capture; a read+write collision is treated as a write
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      op_wr_p0 <= pmem_write;
      idx_p0   <= addr_idx;
      wdata_p0 <= pmem_wdata;
    end
  end

  // Store commit on the RESP->RECOVER edge; an abort by reset suppresses it
  always_ff @(posedge clk) begin
    if (state == RESP && op_wr_p0 && !reset)
      mem[idx_p0] <= wdata_p0;
  end

  // With LATENCY==1 RESP is entered straight from IDLE, before the capture registers hold the request
  assign rd_idx = (state == IDLE) ? addr_idx : idx_p0;
  assign rd_op  = (state == IDLE) ? (pmem_read & ~pmem_write) : ~op_wr_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pmem_rdata <= '0;
    else if (state_nxt == RESP && rd_op)
      pmem_rdata <= mem[rd_idx];
    else
      pmem_rdata <= '0;
  end

`ifdef PMEM_ERRCHK_EN
  logic [15:0] addr_p0;
  logic        rd_p0;
  logic        viol_a, viol_b, viol_c;

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_p0 <= pmem_address;
      rd_p0   <= pmem_read;
    end
  end

  assign viol_a = (state == IDLE) && pmem_read && pmem_write;
  assign viol_b = (state == BUSY || state == RESP) && req &&
                  (pmem_address != addr_p0 || pmem_read != rd_p0 ||
                   pmem_write != op_wr_p0 || pmem_wdata != wdata_p0);
  assign viol_c = (state == BUSY) && !req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pmem_error <= 1'b0;
    else if (viol_a || viol_b || viol_c)
      pmem_error <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (viol_a) $error("pmem_responder: read and write asserted together");
      if (viol_b) $error("pmem_responder: request changed while outstanding");
      if (viol_c) $error("pmem_responder: request dropped before pmem_resp");
    end
  end
`endif
`else
  assign pmem_error = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: u0 is LATENCY=10/INDEX_BITS=12, u1 is LATENCY=1/INDEX_BITS=4.
module tb_pmem_responder;

  typedef struct {
    bit           rd;
    logic [127:0] data;
    int           t;
  } exp_t;

`ifdef PMEM_ERRCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         r0, w0, r1, w1;
  logic [15:0]  a0, a1;
  logic [127:0] wd0, wd1;
  logic         resp0, resp1, err0, err1;
  logic [127:0] rd0, rd1;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  logic p0 = 1'b0, p1 = 1'b0;

  pmem_responder #(.LATENCY(10), .INDEX_BITS(12)) u0 (
    .clk(clk), .reset(reset), .pmem_read(r0), .pmem_write(w0), .pmem_address(a0),
    .pmem_wdata(wd0), .pmem_resp(resp0), .pmem_rdata(rd0), .pmem_error(err0)
  );

  pmem_responder #(.LATENCY(1), .INDEX_BITS(4)) u1 (
    .clk(clk), .reset(reset), .pmem_read(r1), .pmem_write(w1), .pmem_address(a1),
    .pmem_wdata(wd1), .pmem_resp(resp1), .pmem_rdata(rd1), .pmem_error(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon(input int inst, input logic resp, input logic prev, input logic [127:0] rdata);
    exp_t e;
    if (resp) begin
      chk($sformatf("u%0d resp one cycle wide", inst), 128'(prev), 128'(0));
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
        total++;
        $display("FAIL u%0d unexpected resp: got resp=1 expected none (cycle %0d)", inst, cyc);
      end else begin
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("u%0d resp time", inst), 128'(cyc), 128'(e.t));
        if (e.rd) chk($sformatf("u%0d rdata", inst), rdata, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, resp0, p0, rd0);
    mon(1, resp1, p1, rd1);
    p0 = resp0;
    p1 = resp1;
  end

  task automatic set_req(input int inst, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [127:0] wd);
    if (inst == 0) begin r0 = rd; w0 = wr; a0 = addr; wd0 = wd; end
    else           begin r1 = rd; w1 = wr; a1 = addr; wd1 = wd; end
  endtask

  // Issue one request, hold it until resp (or drop it after drop_after negedges), then release.
  task automatic req(input int inst, input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [127:0] wd, input logic [127:0] exp, input int drop_after);
    exp_t e;
    int   n;
    logic got;
    @(posedge clk); #1;
    set_req(inst, rd, wr, addr, wd);
    e.rd   = rd & ~wr;
    e.data = exp;
    e.t    = cyc + ((inst == 0) ? 10 : 1);
    if (inst == 0) q0.push_back(e); else q1.push_back(e);
    n   = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (drop_after > 0 && n == drop_after) set_req(inst, 1'b0, 1'b0, addr, wd);
      got = (inst == 0) ? resp0 : resp1;
    end
    if (!got) begin
      total++;
      $display("FAIL u%0d resp timeout: got no resp expected one within 400 cycles", inst);
    end
    @(posedge clk); #1;
    set_req(inst, 1'b0, 1'b0, 16'h0, 128'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a5, d11, d22, d33, d44, dv1, dv2;
    int           c;
    exp_t         e;
    a5  = {16{8'hA5}};
    d11 = {16{8'h11}};
    d22 = {16{8'h22}};
    d33 = {16{8'h33}};
    d44 = {16{8'h44}};
    dv1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    dv2 = 128'hDEAD_BEEF_0000_1111_2222_3333_C0DE_F00D;
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 16'h0, 128'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 128'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset resp", 128'(resp0), 128'(0));
    chk("reset rdata", rd0, 128'h0);
    chk("reset error", 128'(err0), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // write then read back, and an untouched line
    req(0, 1'b0, 1'b1, 16'h0040, a5, 128'h0, 0);
    req(0, 1'b1, 1'b0, 16'h0040, 128'h0, a5, 0);
    req(0, 1'b1, 1'b0, 16'h0050, 128'h0, 128'h0, 0);
    @(negedge clk);
    chk("rdata zero outside resp", rd0, 128'h0);

    // low address bits ignored, upper bits alias on the narrow instance
    req(1, 1'b0, 1'b1, 16'h1234, dv1, 128'h0, 0);
    req(1, 1'b1, 1'b0, 16'h1238, 128'h0, dv1, 0);
    req(1, 1'b0, 1'b1, 16'h0440, dv2, 128'h0, 0);
    req(1, 1'b1, 1'b0, 16'h0040, 128'h0, dv2, 0);

    // reset during BUSY (cnt=3) aborts the write to 0x0060
    req(0, 1'b0, 1'b1, 16'h0060, d11, 128'h0, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b1, 16'h0060, d22);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 16'h0, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort resp", 128'(resp0), 128'(0));
    chk("abort rdata", rd0, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    req(0, 1'b1, 1'b0, 16'h0060, 128'h0, d11, 0);

    // LATENCY=1 reads with request held: one resp every 3 cycles
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 16'h0040, 128'h0);
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e.rd   = 1'b1;
      e.data = dv2;
      e.t    = c + 1 + 3 * k;
      q1.push_back(e);
    end
    while (cyc < c + 8) @(posedge clk);
    #1;
    set_req(1, 1'b0, 1'b0, 16'h0, 128'h0);

    // read and write together behave as a write
    req(0, 1'b1, 1'b1, 16'h0070, d33, 128'h0, 0);
    @(negedge clk);
    chk("error after rd&wr", 128'(err0), 128'(EXP_ERR));
    req(0, 1'b1, 1'b0, 16'h0070, 128'h0, d33, 0);
    @(negedge clk);
    chk("error sticky", 128'(err0), 128'(EXP_ERR));
    pulse_reset();
    chk("error cleared by reset", 128'(err0), 128'(0));

    // request dropped mid-BUSY still completes and commits
    req(0, 1'b0, 1'b1, 16'h0080, d44, 128'h0, 4);
    req(0, 1'b1, 1'b0, 16'h0080, 128'h0, d44, 0);

    repeat (20) @(posedge clk);
    chk("u0 scoreboard drained", 128'(q0.size()), 128'(0));
    chk("u1 scoreboard drained", 128'(q1.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
